// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int MIN_PRESCALE = 8;

    function automatic logic is_frame_state(input rx_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; last_edge marks the final
// oversampling tick of the current bit.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] ps_q,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      last_edge
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;

    assign last_edge = (edge_cnt_q == (ps_q - PRESCALE_WIDTH'(1)));

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clear) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (enable) begin
            if (last_edge) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_CNT_WIDTH'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM: frame sequencing, checker/sampler enables and
// the data_valid pulse for error-free frames.
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge on RX_IN
//   START  | start bit; strt_glitch at its last edge aborts the frame
//   DATA   | DATA_WIDTH data bits, one deserializer strobe each
//   PARITY | parity bit; par_err latched at its last edge
//   STOP   | stop bit; data_valid issued at its last edge if clean
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      sampled_bit,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid
);

    rx_state_e state_q, state_d;

    logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
    logic [PRESCALE_WIDTH-1:0] ps_load;
    logic [PRESCALE_WIDTH-1:0] ps_m3, ps_m4;
    logic                      par_err_q, par_err_d;

    logic dat_samp_en_q, dat_samp_en_d;
    logic deser_en_q,    deser_en_d;
    logic strt_chk_en_q, strt_chk_en_d;
    logic par_chk_en_q,  par_chk_en_d;
    logic stp_chk_en_q,  stp_chk_en_d;
    logic data_valid_q,  data_valid_d;

    logic last_edge;
    logic cnt_en;
    logic cnt_clear;

    // The majority-voted bit feeds the datapath only; start detection uses the raw line.
    logic unused_sampled_bit;
    assign unused_sampled_bit = sampled_bit;

    assign ps_load = (Prescale < PRESCALE_WIDTH'(MIN_PRESCALE))
                     ? PRESCALE_WIDTH'(MIN_PRESCALE) : Prescale;

    // Enables are registered, so decode one edge early to land on ps_q-2 (and ps_q-3).
    assign ps_m3 = ps_q - PRESCALE_WIDTH'(3);
    assign ps_m4 = ps_q - PRESCALE_WIDTH'(4);

    assign cnt_en    = (state_q != IDLE);
    assign cnt_clear = (state_q == IDLE) || (state_d == IDLE);

    uart_rx_edge_bit_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_counter (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (cnt_en),
        .clear     (cnt_clear),
        .ps_q      (ps_q),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    always_comb begin
        state_d       = state_q;
        ps_d          = ps_q;
        par_err_d     = par_err_q;
        dat_samp_en_d = 1'b0;
        deser_en_d    = 1'b0;
        strt_chk_en_d = 1'b0;
        par_chk_en_d  = 1'b0;
        stp_chk_en_d  = 1'b0;
        data_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    ps_d      = ps_load;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                strt_chk_en_d = (edge_cnt == ps_m3);
                if (last_edge) begin
                    state_d = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                deser_en_d = (edge_cnt == ps_m3);
                if (last_edge && (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH))) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_chk_en_d = (edge_cnt == ps_m4) || (edge_cnt == ps_m3);
                if (last_edge) begin
                    state_d   = STOP;
                    par_err_d = par_err;
                end
            end
            STOP: begin
                stp_chk_en_d = (edge_cnt == ps_m3);
                if (last_edge) begin
                    state_d      = IDLE;
                    data_valid_d = !par_err_q && !stp_err;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dat_samp_en_d = is_frame_state(state_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            ps_q          <= PRESCALE_WIDTH'(MIN_PRESCALE);
            par_err_q     <= 1'b0;
            dat_samp_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            strt_chk_en_q <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ps_q          <= ps_d;
            par_err_q     <= par_err_d;
            dat_samp_en_q <= dat_samp_en_d;
            deser_en_q    <= deser_en_d;
            strt_chk_en_q <= strt_chk_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign dat_samp_en = dat_samp_en_q;
    assign deser_en    = deser_en_q;
    assign strt_chk_en = strt_chk_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign data_valid  = data_valid_q;

endmodule
